// File: rtl/alu_flag_sequencer.sv
// -----------------------------------------------------------------------------
// alu_flag_sequencer
//   Multi-cycle ALU stage that sits directly upstream of the CPU flags register.
//   An operation is accepted with start while idle. Arithmetic, logic and CMP
//   finish in one cycle. Shifts and rotates move one bit per cycle. An optional
//   shift-add multiply takes WIDTH cycles. The result and the {N,Z,V,C} flag
//   nibble are presented together with a one-cycle done pulse and write strobes.
//
//   Optional feature macro: ALU_MUL_EN
//     defined   : opcode D is an iterative unsigned multiply (low WIDTH bits,
//                 C = any high-half product bit set).
//     undefined : opcode D behaves like reserved F and no multiplier is built.
//
//   Ports
//     clk        system clock, rising edge
//     rst        asynchronous active-high reset
//     start      request, sampled only while idle
//     opcode     operation select, latched on accept
//     a, b       operands (b[SHW-1:0] is the shift amount), latched on accept
//     carry_in   current carry flag for ADC/SBC, latched on accept
//     busy       high from the cycle after accept through the done cycle
//     done       one-cycle completion pulse
//     result     registered result, held until the next write
//     result_we  with done: result is to be written back
//     flags_out  {N,Z,V,C}, held until the next write
//     flags_we   with done: flags register write strobe
// -----------------------------------------------------------------------------
module alu_flag_sequencer #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_we,
    output logic [3:0]       flags_out,
    output logic             flags_we
);

    localparam int CNT_W = SHW + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{SHW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MUL_COUNT = CNT_W'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ASR = 4'hA, OP_ROL = 4'hB;
    localparam logic [3:0] OP_ROR = 4'hC, OP_MUL = 4'hD, OP_CMP = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [3:0]         op_r, op_nxt_s;
    logic [WIDTH-1:0]   acc_r, acc_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]   result_r, result_nxt_s;
    logic [3:0]         flags_r, flags_nxt_s;
    logic               busy_r, done_r, result_we_r, flags_we_r;
    logic               rwe_nxt_s, fwe_nxt_s;
    logic [WIDTH+3:0]   single_s;
    logic [WIDTH:0]     step_s;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod_r, prod_nxt_s, prod_step_s;
    logic [WIDTH-1:0]   mcand_r, mcand_nxt_s;
`endif

    // Single-cycle ops: returns {N,Z,V,C, result}; arithmetic uses one extra bit for carry/borrow.
    function automatic logic [WIDTH+3:0] alu_single(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y, input logic cin);
        logic [WIDTH:0]   ext_s;
        logic [WIDTH-1:0] r_s;
        logic             c_s, v_s;
        ext_s = {(WIDTH+1){1'b0}};
        r_s   = x;
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                ext_s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin & (op == OP_ADC)};
                r_s   = ext_s[WIDTH-1:0];
                c_s   = ext_s[WIDTH];
                v_s   = (x[WIDTH-1] == y[WIDTH-1]) && (r_s[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                // Bit WIDTH of the extended difference is the borrow (a < b + borrow_in).
                ext_s = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, cin & (op == OP_SBC)};
                r_s   = ext_s[WIDTH-1:0];
                c_s   = ext_s[WIDTH];
                v_s   = (x[WIDTH-1] != y[WIDTH-1]) && (r_s[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:  r_s = x & y;
            OP_OR:   r_s = x | y;
            OP_XOR:  r_s = x ^ y;
            OP_NOT:  r_s = ~x;
            default: r_s = x;
        endcase
        return {r_s[WIDTH-1], (r_s == {WIDTH{1'b0}}), v_s, c_s, r_s};
    endfunction

    // One-bit shift/rotate step: returns {bit shifted out, new value}.
    function automatic logic [WIDTH:0] shift_step(input logic [3:0] op, input logic [WIDTH-1:0] x);
        case (op)
            OP_SHL:  return {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
            OP_SHR:  return {x[0], 1'b0, x[WIDTH-1:1]};
            OP_ASR:  return {x[0], x[WIDTH-1], x[WIDTH-1:1]};
            OP_ROL:  return {x[WIDTH-1], x[WIDTH-2:0], x[WIDTH-1]};
            OP_ROR:  return {x[0], x[0], x[WIDTH-1:1]};
            default: return {1'b0, x};
        endcase
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

    function automatic logic is_single(input logic [3:0] op);
        return (op <= OP_NOT) || (op == OP_CMP);
    endfunction

`ifdef ALU_MUL_EN
    // Shift-add step: low half holds the remaining multiplier bits, high half the partial sum.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p, input logic [WIDTH-1:0] m);
        logic [WIDTH:0] sum_s;
        sum_s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum_s, p[WIDTH-1:1]};
    endfunction
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign result_we = result_we_r;
    assign flags_out = flags_r;
    assign flags_we  = flags_we_r;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start) begin
                    state_nxt_s = ST_IDLE;
                end else if (is_shift(opcode)) begin
                    if (b[SHW-1:0] == {SHW{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
`ifdef ALU_MUL_EN
                end else if (opcode == OP_MUL) begin
                    state_nxt_s = ST_MUL;
`endif
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
`endif
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and datapath next values; results/flags/strobes change only when entering DONE.
    always_comb begin
        op_nxt_s     = op_r;
        acc_nxt_s    = acc_r;
        cnt_nxt_s    = cnt_r;
        result_nxt_s = result_r;
        flags_nxt_s  = flags_r;
        rwe_nxt_s    = 1'b0;
        fwe_nxt_s    = 1'b0;
        single_s     = alu_single(opcode, a, b, carry_in);
        step_s       = shift_step(op_r, acc_r);
`ifdef ALU_MUL_EN
        prod_nxt_s   = prod_r;
        mcand_nxt_s  = mcand_r;
        prod_step_s  = mul_step(prod_r, mcand_r);
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_nxt_s  = opcode;
                    acc_nxt_s = a;
                    cnt_nxt_s = {1'b0, b[SHW-1:0]};
                    if (is_single(opcode)) begin
                        flags_nxt_s = single_s[WIDTH+3:WIDTH];
                        fwe_nxt_s   = 1'b1;
                        if (opcode != OP_CMP) begin
                            result_nxt_s = single_s[WIDTH-1:0];
                            rwe_nxt_s    = 1'b1;
                        end else begin
                            result_nxt_s = result_r;
                        end
                    end else if (is_shift(opcode)) begin
                        // A zero amount completes at once with the operand unchanged and C=0.
                        if (b[SHW-1:0] == {SHW{1'b0}}) begin
                            result_nxt_s = a;
                            flags_nxt_s  = {a[WIDTH-1], (a == {WIDTH{1'b0}}), 2'b00};
                            rwe_nxt_s    = 1'b1;
                            fwe_nxt_s    = 1'b1;
                        end else begin
                            result_nxt_s = result_r;
                        end
`ifdef ALU_MUL_EN
                    end else if (opcode == OP_MUL) begin
                        cnt_nxt_s   = MUL_COUNT;
                        prod_nxt_s  = {{WIDTH{1'b0}}, b};
                        mcand_nxt_s = a;
`endif
                    end else begin
                        // Reserved opcodes complete without touching result or flags.
                        result_nxt_s = result_r;
                    end
                end else begin
                    op_nxt_s = op_r;
                end
            end
            ST_SHIFT: begin
                acc_nxt_s = step_s[WIDTH-1:0];
                cnt_nxt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    result_nxt_s = step_s[WIDTH-1:0];
                    flags_nxt_s  = {step_s[WIDTH-1], (step_s[WIDTH-1:0] == {WIDTH{1'b0}}), 1'b0, step_s[WIDTH]};
                    rwe_nxt_s    = 1'b1;
                    fwe_nxt_s    = 1'b1;
                end else begin
                    result_nxt_s = result_r;
                end
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                prod_nxt_s = prod_step_s;
                cnt_nxt_s  = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    result_nxt_s = prod_step_s[WIDTH-1:0];
                    flags_nxt_s  = {prod_step_s[WIDTH-1], (prod_step_s[WIDTH-1:0] == {WIDTH{1'b0}}),
                                    1'b0, (|prod_step_s[2*WIDTH-1:WIDTH])};
                    rwe_nxt_s    = 1'b1;
                    fwe_nxt_s    = 1'b1;
                end else begin
                    result_nxt_s = result_r;
                end
            end
`endif
            ST_DONE: result_nxt_s = result_r;
            default: result_nxt_s = result_r;
        endcase
    end

    // Output and datapath registers; busy/done decode the upcoming state so they are flop outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= 4'h0;
            acc_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            flags_r     <= 4'h0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_we_r <= 1'b0;
            flags_we_r  <= 1'b0;
`ifdef ALU_MUL_EN
            prod_r      <= {(2*WIDTH){1'b0}};
            mcand_r     <= {WIDTH{1'b0}};
`endif
        end else begin
            op_r        <= op_nxt_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            result_r    <= result_nxt_s;
            flags_r     <= flags_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
            result_we_r <= rwe_nxt_s;
            flags_we_r  <= fwe_nxt_s;
`ifdef ALU_MUL_EN
            prod_r      <= prod_nxt_s;
            mcand_r     <= mcand_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_alu_flag_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_flag_sequencer
//   Scoreboard bench for alu_flag_sequencer. Each issued operation pushes its
//   expected result, flags, strobes and latency (from an arithmetic reference
//   model) into a queue; a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_alu_flag_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   opcode = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         busy, done, result_we, flags_we;
    logic [W-1:0] result;
    logic [3:0]   flags_out;

    alu_flag_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy), .done(done), .result(result),
        .result_we(result_we), .flags_out(flags_out), .flags_we(flags_we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        bit           rwe;
        bit           fwe;
        int           lat;
        int           acc;
        logic [3:0]   op;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] m_res = '0;
    logic [3:0]   m_flg = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit msb(input longint v);
        return ((v >> (W - 1)) & 1) != 0;
    endfunction

    // Reference model: plain integer arithmetic over the whole operation.
    function automatic exp_t model(input logic [3:0] op, input longint x, input longint y, input bit cin);
        exp_t   e;
        longint mask, r, p, sx, bin;
        int     n;
        bit     c, v, wr, wf;
        mask = (longint'(1) << W) - 1;
        n    = int'(y % W);
        r = 0; p = 0; sx = 0; bin = 0;
        c = 0; v = 0; wr = 1; wf = 1;
        e.lat = 1;
        e.op  = op;
        case (op)
            4'h0, 4'h1: begin
                r = x + y + ((op == 4'h1) ? longint'(cin) : 0);
                c = ((r >> W) & 1) != 0;
                r = r & mask;
                v = (msb(x) == msb(y)) && (msb(r) != msb(x));
            end
            4'h2, 4'h3, 4'hE: begin
                bin = (op == 4'h3) ? longint'(cin) : 0;
                c = x < (y + bin);
                r = (x - y - bin) & mask;
                v = (msb(x) != msb(y)) && (msb(r) != msb(x));
                if (op == 4'hE) wr = 0;
            end
            4'h4: r = x & y;
            4'h5: r = x | y;
            4'h6: r = x ^ y;
            4'h7: r = ~x & mask;
            4'h8: begin r = (x << n) & mask; c = (n != 0) && (((x >> (W - n)) & 1) != 0); e.lat = n + 1; end
            4'h9: begin r = x >> n; c = (n != 0) && (((x >> (n - 1)) & 1) != 0); e.lat = n + 1; end
            4'hA: begin
                sx = msb(x) ? (x - (longint'(1) << W)) : x;
                r = (sx >>> n) & mask;
                c = (n != 0) && (((x >> (n - 1)) & 1) != 0);
                e.lat = n + 1;
            end
            4'hB: begin r = ((x << n) | (x >> (W - n))) & mask; c = (n != 0) && ((r & 1) != 0); e.lat = n + 1; end
            4'hC: begin r = ((x >> n) | (x << (W - n))) & mask; c = (n != 0) && msb(r); e.lat = n + 1; end
`ifdef ALU_MUL_EN
            4'hD: begin p = x * y; r = p & mask; c = (p >> W) != 0; e.lat = W + 1; end
`endif
            default: begin wr = 0; wf = 0; end
        endcase
        e.rwe = wr;
        e.fwe = wf;
        e.res = wr ? W'(r) : m_res;
        e.flg = wf ? {msb(r), (r == 0), v, c} : m_flg;
        e.acc = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("result op%0h", mon_e.op), result, mon_e.res);
                check($sformatf("flags op%0h", mon_e.op), flags_out, mon_e.flg);
                check($sformatf("result_we op%0h", mon_e.op), result_we, mon_e.rwe);
                check($sformatf("flags_we op%0h", mon_e.op), flags_we, mon_e.fwe);
                check($sformatf("latency op%0h", mon_e.op), cyc + 1 - mon_e.acc, mon_e.lat);
                check("busy_at_done", busy, 1'b1);
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || done || sb.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got still busy after %0d cycles expected idle", t);
            sb.delete();
        end
    endtask

    // Issue one op, then optionally pulse start while busy (must be ignored).
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit cin, input int junk);
        exp_t e;
        wait_idle();
        opcode = op; a = x; b = y; carry_in = cin; start = 1'b1;
        e = model(op, longint'(x), longint'(y), cin);
        e.acc = cyc + 1;
        sb.push_back(e);
        m_res = e.res;
        m_flg = e.flg;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < junk; i++) begin
            opcode = 4'($urandom); a = W'($urandom); b = W'($urandom);
            start = busy;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] ra, rb;
    logic [3:0]   rop;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 16'h0000);
        check("reset_flags", flags_out, 4'h0);
        check("reset_we", {result_we, flags_we}, 2'b00);
        rst = 1'b0;

        // Directed cases
        issue(4'h0, 16'h7FFF, 16'h0001, 1'b0, 0);   // ADD: 0x8000, NZVC=1010
        issue(4'h2, 16'h0001, 16'h0002, 1'b0, 0);   // SUB: 0xFFFF, 1001
        issue(4'h8, 16'h8001, 16'h0003, 1'b0, 3);   // SHL by 3 with stray starts
        issue(4'hE, 16'h0005, 16'h0005, 1'b0, 1);   // CMP equal: 0100, result kept
        issue(4'hF, 16'h1234, 16'h5678, 1'b1, 1);   // reserved: no writes
        issue(4'hD, 16'h0100, 16'h0100, 1'b0, 2);   // MUL (or reserved)
        issue(4'h1, 16'hFFFF, 16'h0000, 1'b1, 0);   // ADC wrap
        issue(4'h3, 16'h0000, 16'h0000, 1'b1, 0);   // SBC borrow-in
        issue(4'h3, 16'h8000, 16'h0001, 1'b0, 0);   // SBC signed overflow
        issue(4'hA, 16'h8000, 16'h000F, 1'b0, 0);   // ASR max amount
        issue(4'hC, 16'h0001, 16'h0010, 1'b0, 0);   // ROR amount 0
        issue(4'hB, 16'h8000, 16'h0001, 1'b0, 0);   // ROL by 1
        issue(4'h9, 16'h0003, 16'h0001, 1'b0, 0);   // SHR by 1
        issue(4'h7, 16'hFFFF, 16'h0000, 1'b0, 0);   // NOT -> zero

        // Reset in the middle of a long shift aborts with no done afterwards
        issue(4'h8, 16'h0001, 16'h000A, 1'b0, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 16'h0000);
        sb.delete();
        m_res = '0;
        m_flg = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        issue(4'h0, 16'h0002, 16'h0003, 1'b0, 0);

        // Randomized operations
        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom);
            ra  = W'($urandom);
            rb  = W'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 16'h7FFF;
                1: ra = 16'h8000;
                2: rb = ra;
                default: ra = ra;
            endcase
            issue(rop, ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_flag_sequencer.md
Name: alu_flag_sequencer

Overview:
- Multi-cycle ALU stage directly upstream of the CPU flags register.
- Accepts an operation with a start/busy/done handshake and computes the result plus a 4-bit flags nibble.
- Drives the flags register's write strobe and bus input.
- Single-cycle ops finish in one cycle; shifts/rotates run one bit per cycle; optional iterative multiply.

Parameters:
- WIDTH, 16, operand/result width in bits (power of two, >= 8).
- SHW, $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- opcode  input  4  operation select, latched on accept
- a  input  WIDTH  operand A, latched on accept
- b  input  WIDTH  operand B / shift amount, latched on accept
- carry_in  input  1  current carry flag (flags[0]) for ADC/SBC, latched on accept
- busy  output  1  high from accept cycle+1 until done cycle inclusive
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  registered result, held until next done
- result_we  output  1  with done: result is to be written back
- flags_out  output  4  {N,Z,V,C} = bits [3:0] as {3,2,1,0}; held until next done
- flags_we  output  1  with done: flags register cs_in strobe

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, result=0, result_we=0, flags_out=0, flags_we=0, counters=0.
- FSM states:
  - IDLE: start=1 latches inputs.
    - Single-cycle op -> DONE.
    - Shift/rotate with amount=0 -> DONE.
    - Shift/rotate with amount>0 -> SHIFT (counter=amount).
    - MUL -> MUL (counter=WIDTH).
  - SHIFT: one bit per cycle, counter--; counter reaches 0 -> DONE.
  - MUL: one shift-add step per cycle; after WIDTH steps -> DONE.
  - DONE: done=1 plus write strobes for exactly one cycle -> IDLE.
- Latency, counted from the accept edge to the edge at which done is observed high:
  - single-cycle ops: 1 cycle.
  - shift by n: n+1 cycles.
  - MUL: WIDTH+1 cycles.
- start while busy (SHIFT/MUL/DONE) is ignored and not queued.
- start in the DONE cycle is ignored; the earliest next accept is the cycle after done.
- Opcodes:
  - 0 ADD: a+b
  - 1 ADC: a+b+carry_in
  - 2 SUB: a-b
  - 3 SBC: a-b-carry_in
  - 4 AND, 5 OR, 6 XOR
  - 7 NOT: ~a
  - 8 SHL, 9 SHR (logical), A ASR
  - B ROL, C ROR
  - D MUL (optional)
  - E CMP: a-b, flags only
  - F reserved
- Flag rules:
  - N = result[WIDTH-1]; Z = (result==0). For CMP, both use the difference.
  - ADD/ADC: C = unsigned carry out; V = signed overflow (same operand signs, different result sign).
  - SUB/SBC/CMP: C = borrow (unsigned a < b + borrow_in); V = signed overflow (operand signs differ, result sign differs from a).
  - Logic ops and NOT: C=0, V=0.
  - Shifts/rotates: C = last bit shifted/rotated out (0 when amount=0); V=0.
  - ASR replicates the MSB.
  - Arithmetic is computed at WIDTH+1 bits; result is truncated to WIDTH.
- Write strobes (done cycle):
  - result_we=1 and flags_we=1 for all ops except CMP and F.
  - CMP: result_we=0, flags_we=1; result register unchanged.
  - F: result_we=0, flags_we=0; result and flags_out unchanged.
- Reset asserted mid-operation aborts immediately; no done pulse is produced afterwards.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined:
  - opcode D is an unsigned shift-add multiply over WIDTH cycles.
  - result = low WIDTH bits of the product.
  - C = 1 if any high-half product bit is set; V=0; N/Z from result.
- Undefined:
  - opcode D behaves exactly as reserved F: done after 1 cycle, no writes.
  - No multiplier datapath or MUL state is synthesized.

Test Plan:
- ADD a=0x7FFF b=0x0001 -> done 1 cycle after accept; result=0x8000; flags_out=4'b1010; result_we=flags_we=1.
- SUB a=0x0001 b=0x0002 -> result=0xFFFF; flags_out=4'b1001 (N, C=borrow).
- SHL a=0x8001 b=3 -> busy for 3 SHIFT cycles plus DONE; done at cycle 4; result=0x0008; flags_out=4'b0000. A start pulse mid-shift is ignored.
- CMP a=0x0005 b=0x0005 -> flags_out=4'b0100; flags_we=1; result_we=0; result unchanged.
- Assert rst during SHL by 10 (cycle 3) -> busy=0, done=0 immediately; no done pulse afterwards; a fresh ADD then completes normally.
- MUL a=0x0100 b=0x0100:
  - with ALU_MUL_EN: done at cycle 17; result=0x0000; flags_out=4'b0101.
  - without: done at cycle 1; result_we=flags_we=0.
